local_eject_port: RTL and testbench
===================================

Name: local_eject_port

Overview:
- Receiver and ejection unit on the router's local output. It is the far end of the router's credit-based flow control.
- Accepts flits from the router local output into a DEPTH-entry FIFO and presents them to the attached core with a valid/ready handshake.
- Tracks packet framing (head/body/tail) and marks start and end of packet for the core.
- Returns one credit pulse to the router's local credit-increment input for every flit consumed by the core.

Parameters:
FLIT_W, 32, flit width in bits; bits [FLIT_W-1:FLIT_W-2] hold the flit type
DEPTH, 4, FIFO entries; equals the router's local-port credit count at reset
CNT_W, 16, width of the completed-packet counter

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
flit_i  input  FLIT_W  flit from router local output
flit_valid_i  input  1  flit_i carries a flit this cycle
l_incr_o  output  1  credit-return pulse to router local credit-increment input
core_flit_o  output  FLIT_W  head-of-FIFO flit
core_valid_o  output  1  FIFO non-empty
core_ready_i  input  1  core accepts core_flit_o this cycle
core_sop_o  output  1  presented flit starts a packet
core_eop_o  output  1  presented flit ends a packet
pkt_count_o  output  CNT_W  completed packets delivered, wraps
occupancy_o  output  $clog2(DEPTH+1)  current FIFO fill level
overflow_err_o  output  1  sticky: flit arrived with no free slot
proto_err_o  output  1  sticky: framing violation seen

Behaviour:
- Reset (synchronous, active-high, one clock/reset domain):
  - FIFO emptied and state = IDLE.
  - l_incr_o, core_valid_o, core_sop_o, core_eop_o, overflow_err_o and proto_err_o = 0.
  - pkt_count_o = 0 and occupancy_o = 0.
  - A push or pop in the reset cycle is ignored.
  - Reset mid-packet discards stored flits and returns no credits for them; the router credit counter is reset in the same cycle.
- Flit type encoding: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE.
- FIFO is first-word-fall-through:
  - core_flit_o = oldest entry.
  - core_valid_o = (occupancy != 0), combinational from registered state.
- Pop = core_valid_o & core_ready_i.
- Push = flit_valid_i & (occupancy < DEPTH or pop).
  - Simultaneous push and pop when full: both happen, occupancy is unchanged.
  - Simultaneous push and pop when empty: the pushed flit is not visible until the next cycle. There is no bypass path.
- flit_valid_i while full with no pop: flit is dropped, overflow_err_o set, occupancy unchanged, no credit is generated.
- Pointers wrap modulo DEPTH. occupancy_o stays within 0..DEPTH.
- Credit return:
  - l_incr_o is registered and equals 1 in the cycle after each pop (1-cycle latency).
  - One pulse per popped flit; back-to-back pops give a continuous high.
  - Total pulses always equal total pops.
- Framing FSM (states IDLE, IN_PKT) advances only on pop. Head flit type = T.
  - IDLE, T=HEAD: sop=1, eop=0, go to IN_PKT.
  - IDLE, T=SINGLE: sop=1, eop=1, pkt_count+1, stay IDLE.
  - IDLE, T=BODY or TAIL: sop=0, eop=0, proto_err set, flit still delivered, stay IDLE.
  - IN_PKT, T=BODY: sop=0, eop=0, stay IN_PKT.
  - IN_PKT, T=TAIL: eop=1, pkt_count+1, go to IDLE.
  - IN_PKT, T=HEAD: proto_err set, sop=1, stay IN_PKT (new packet, old one abandoned, not counted).
  - IN_PKT, T=SINGLE: proto_err set, sop=1, eop=1, pkt_count+1, go to IDLE.
- core_sop_o / core_eop_o are combinational from state and head flit type. They are meaningful only while core_valid_o=1 and are forced to 0 otherwise.
- pkt_count_o wraps from 2^CNT_W-1 to 0.
- Error flags stay set until rst.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with flit_valid_i=1 -> occupancy_o=0, all outputs 0, no l_incr_o pulse.
- Packet delivery: push HEAD, BODY, TAIL, core_ready_i=1 -> core sees sop on flit 1 and eop on flit 3, pkt_count_o=1, three l_incr_o pulses each one cycle after its pop.
- Full FIFO: core_ready_i=0, push 5 flits with DEPTH=4 -> occupancy_o=4, 5th flit dropped, overflow_err_o=1, no credits. Then set ready=1 -> 4 flits out in order, 4 credit pulses.
- Full plus simultaneous push/pop: occupancy_o=4, flit_valid_i=1 and core_ready_i=1 for 3 cycles -> occupancy stays 4, no overflow, 3 credit pulses, order preserved.
- Framing errors: pop BODY in IDLE -> proto_err_o=1, pkt_count_o unchanged. Then HEAD, HEAD, TAIL -> pkt_count_o=1, sop asserted on both HEADs.
- Wrap and mid-packet reset: CNT_W=4, deliver 17 SINGLE flits -> pkt_count_o=1. Push HEAD, BODY, then rst -> FIFO empty, state IDLE, no credits for discarded flits.

Source files
------------

// File: rtl/local_eject_port.sv
// Local ejection port: first-word-fall-through flit FIFO toward the core,
// packet framing tracker, and one credit pulse back to the router per consumed flit.
module local_eject_port #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_W-1:0]            flit_i,
  input  logic                         flit_valid_i,
  output logic                         l_incr_o,
  output logic [FLIT_W-1:0]            core_flit_o,
  output logic                         core_valid_o,
  input  logic                         core_ready_i,
  output logic                         core_sop_o,
  output logic                         core_eop_o,
  output logic [CNT_W-1:0]             pkt_count_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic                         overflow_err_o,
  output logic                         proto_err_o,
  output logic                         state_o
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              full, pop, push;
  logic              frame_err, pkt_done;
  logic [1:0]        head_type;

  // Handshake: a flit moves to the core on any cycle where core_valid_o and
  // core_ready_i are both high; valid never depends on ready.
  assign full         = (occ == FULL_LVL);
  assign core_valid_o = (occ != '0);
  assign core_flit_o  = mem[rd_ptr];
  assign head_type    = core_flit_o[FLIT_W-1 -: 2];
  assign pop          = core_valid_o & core_ready_i;
  assign push         = flit_valid_i & (~full | pop);
  assign occupancy_o  = occ;
  assign state_o      = state_q;

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= flit_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      occ            <= '0;
      l_incr_o       <= 1'b0;
      state_q        <= IDLE;
      pkt_count_o    <= '0;
      overflow_err_o <= 1'b0;
      proto_err_o    <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: ;
      endcase
      // Credit returns exactly the flits the core consumed, one cycle late.
      l_incr_o <= pop;
      state_q  <= state_d;
      if (pkt_done) pkt_count_o <= pkt_count_o + CNT_W'(1);
      if (flit_valid_i && !push) overflow_err_o <= 1'b1;
      if (frame_err) proto_err_o <= 1'b1;
    end
  end

  // Framing decode of the presented flit; state only moves when it is popped.
  always_comb begin
    state_d    = state_q;
    core_sop_o = 1'b0;
    core_eop_o = 1'b0;
    frame_err  = 1'b0;
    pkt_done   = 1'b0;
    if (core_valid_o) begin
      case (state_q)
        IDLE: begin
          case (head_type)
            T_HEAD: begin
              core_sop_o = 1'b1;
              if (pop) state_d = IN_PKT;
            end
            T_SINGLE: begin
              core_sop_o = 1'b1;
              core_eop_o = 1'b1;
              pkt_done   = pop;
            end
            default: frame_err = pop;
          endcase
        end
        IN_PKT: begin
          case (head_type)
            T_BODY: ;
            T_TAIL: begin
              core_eop_o = 1'b1;
              pkt_done   = pop;
              if (pop) state_d = IDLE;
            end
            T_HEAD: begin
              core_sop_o = 1'b1;
              frame_err  = pop;
            end
            default: begin
              core_sop_o = 1'b1;
              core_eop_o = 1'b1;
              frame_err  = pop;
              pkt_done   = pop;
              if (pop) state_d = IDLE;
            end
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_local_eject_port.sv
// Bench for local_eject_port: directed flit streams, a flit/sop/eop scoreboard,
// and a cycle model of occupancy, overflow and credit return.
module tb_local_eject_port;

  localparam int FLIT_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_SINGLE = 2'b11;

  logic              clk = 1'b0;
  logic              rst;
  logic [FLIT_W-1:0] flit_i;
  logic              flit_valid_i;
  logic              l_incr_o;
  logic [FLIT_W-1:0] core_flit_o;
  logic              core_valid_o;
  logic              core_ready_i;
  logic              core_sop_o;
  logic              core_eop_o;
  logic [CNT_W-1:0]  pkt_count_o;
  logic [OCC_W-1:0]  occupancy_o;
  logic              overflow_err_o;
  logic              proto_err_o;
  logic              state_o;

  local_eject_port #(.FLIT_W(FLIT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flit_i(flit_i), .flit_valid_i(flit_valid_i),
    .l_incr_o(l_incr_o), .core_flit_o(core_flit_o), .core_valid_o(core_valid_o),
    .core_ready_i(core_ready_i), .core_sop_o(core_sop_o), .core_eop_o(core_eop_o),
    .pkt_count_o(pkt_count_o), .occupancy_o(occupancy_o),
    .overflow_err_o(overflow_err_o), .proto_err_o(proto_err_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int seq      = 1;

  logic [FLIT_W+1:0] exp_q[$];
  logic              exp_sop_d, exp_eop_d;
  int                model_occ = 0;
  logic              exp_l_incr = 1'b0;
  logic              exp_ovf = 1'b0;
  logic              chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: occupancy, overflow, credits ----------------
  always @(negedge clk) begin
    logic mpop, mpush;
    if (chk_en) begin
      check("occupancy", 32'(occupancy_o), 32'(model_occ));
      check("core_valid", 32'(core_valid_o), 32'(model_occ != 0));
      check("l_incr", 32'(l_incr_o), 32'(exp_l_incr));
      check("overflow_err", 32'(overflow_err_o), 32'(exp_ovf));
    end
    if (rst) begin
      model_occ  = 0;
      exp_l_incr = 1'b0;
      exp_ovf    = 1'b0;
      exp_q.delete();
      chk_en     = 1'b1;
    end else begin
      mpop  = (model_occ != 0) && core_ready_i;
      mpush = flit_valid_i && ((model_occ < DEPTH) || mpop);
      if (flit_valid_i && !mpush) exp_ovf = 1'b1;
      if (mpush) exp_q.push_back({exp_sop_d, exp_eop_d, flit_i});
      model_occ  = model_occ + int'(mpush) - int'(mpop);
      exp_l_incr = mpop;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [FLIT_W+1:0] e;
    if (chk_en && !rst) begin
      if (core_valid_o && core_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_flit: got %0h expected none", core_flit_o);
        end else begin
          e = exp_q.pop_front();
          check("flit", core_flit_o, e[FLIT_W-1:0]);
          check("sop", 32'(core_sop_o), 32'(e[FLIT_W+1]));
          check("eop", 32'(core_eop_o), 32'(e[FLIT_W]));
        end
      end
      if (!core_valid_o) begin
        check("sop_idle", 32'(core_sop_o), 32'd0);
        check("eop_idle", 32'(core_eop_o), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] t, input logic s, input logic e, input logic rdy);
    @(posedge clk); #1;
    flit_valid_i = 1'b1;
    flit_i       = {t, 30'(seq)};
    exp_sop_d    = s;
    exp_eop_d    = e;
    core_ready_i = rdy;
    seq++;
  endtask

  task automatic idle(input logic rdy);
    @(posedge clk); #1;
    flit_valid_i = 1'b0;
    core_ready_i = rdy;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    flit_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    idle(1'b1);
    while (model_occ != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (model_occ != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got occupancy %0d expected 0", model_occ);
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; flit_valid_i = 1'b1; flit_i = 32'hdead_beef;
    core_ready_i = 1'b0; exp_sop_d = 1'b0; exp_eop_d = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; flit_valid_i = 1'b0;
    @(negedge clk);
    check("rst_pkt_count", 32'(pkt_count_o), 32'd0);
    check("rst_proto_err", 32'(proto_err_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);

    // one HEAD/BODY/TAIL packet
    send(T_HEAD, 1'b1, 1'b0, 1'b1);
    send(T_BODY, 1'b0, 1'b0, 1'b1);
    send(T_TAIL, 1'b0, 1'b1, 1'b1);
    drain();
    check("pkt_pkt_count", 32'(pkt_count_o), 32'd1);
    check("pkt_proto_err", 32'(proto_err_o), 32'd0);

    // fill past capacity with the core stalled
    send(T_HEAD, 1'b1, 1'b0, 1'b0);
    send(T_BODY, 1'b0, 1'b0, 1'b0);
    send(T_BODY, 1'b0, 1'b0, 1'b0);
    send(T_TAIL, 1'b0, 1'b1, 1'b0);
    send(T_SINGLE, 1'b1, 1'b1, 1'b0);
    idle(1'b0);
    @(negedge clk);
    check("full_occupancy", 32'(occupancy_o), 32'd4);
    check("full_overflow", 32'(overflow_err_o), 32'd1);
    drain();
    check("full_pkt_count", 32'(pkt_count_o), 32'd2);

    // full FIFO with simultaneous push and pop
    do_reset();
    repeat (4) send(T_SINGLE, 1'b1, 1'b1, 1'b0);
    repeat (3) send(T_SINGLE, 1'b1, 1'b1, 1'b1);
    idle(1'b0);
    @(negedge clk);
    check("pp_occupancy", 32'(occupancy_o), 32'd4);
    check("pp_overflow", 32'(overflow_err_o), 32'd0);
    drain();
    check("pp_pkt_count", 32'(pkt_count_o), 32'd7);

    // framing errors
    do_reset();
    send(T_BODY, 1'b0, 1'b0, 1'b1);
    drain();
    check("body_idle_proto_err", 32'(proto_err_o), 32'd1);
    check("body_idle_pkt_count", 32'(pkt_count_o), 32'd0);
    send(T_HEAD, 1'b1, 1'b0, 1'b1);
    send(T_HEAD, 1'b1, 1'b0, 1'b1);
    send(T_TAIL, 1'b0, 1'b1, 1'b1);
    drain();
    check("hht_pkt_count", 32'(pkt_count_o), 32'd1);
    check("hht_state", 32'(state_o), 32'd0);

    // counter wrap, then reset in the middle of a packet
    do_reset();
    repeat (17) send(T_SINGLE, 1'b1, 1'b1, 1'b1);
    drain();
    check("wrap_pkt_count", 32'(pkt_count_o), 32'd1);
    send(T_HEAD, 1'b1, 1'b0, 1'b0);
    send(T_BODY, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk);
    check("midpkt_state", 32'(state_o), 32'd1);
    do_reset();
    @(negedge clk);
    check("midrst_occupancy", 32'(occupancy_o), 32'd0);
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_valid", 32'(core_valid_o), 32'd0);
    check("midrst_pkt_count", 32'(pkt_count_o), 32'd0);
    repeat (3) idle(1'b1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
